niosqsys_control_words_tx: RTL
==============================

// Module: niosqsys_control_words_tx
// PURPOSE
//  Avalon-MM slave output port. Counterpart of the control-word input PIO: Nios writes
//  control words and the block delivers them to fabric logic over valid/ack. Buffers up
//  to DEPTH words so software can post bursts. Exposes status and sticky overflow to SW.
// PARAMETERS
//  DATA_WIDTH  12  width of one control word / out_port
//  DEPTH       4   FIFO entries, power of 2, 2..16
// PORTS
//  clk        in   1           system clock
//  reset_n    in   1           reset, asynchronous, active-low
//  address    in   2           Avalon word address
//  chipselect in   1           Avalon select
//  write_n    in   1           Avalon write strobe, active-low
//  writedata  in   32          Avalon write data
//  readdata   out  32          Avalon read data, registered
//  out_port   out  DATA_WIDTH  control word presented to fabric
//  out_valid  out  1           out_port holds an undelivered word
//  out_ack    in   1           fabric consumes word when out_valid & out_ack
// BEHAVIOUR
//  Reset: readdata=0, out_port=0, out_valid=0, FIFO empty, level=0, overflow=0.
//  Register map (wr = chipselect & ~write_n):
//   0 DATA  W: push writedata[DATA_WIDTH-1:0]; upper bits ignored. R: out_port, zero-ext.
//   1 STAT  R: [0] idle (FIFO empty & ~out_valid), [1] full, [8:4] level, [9] out_valid,
//              [16] overflow. W: [0]=1 flush, [16]=1 clear overflow; other bits ignored.
//   2,3     R: 0. W: ignored.
//  readdata: registered every clk from mux(address), no read strobe needed; latency 1.
//  Push: accepted if not full, or full with pop in same cycle (level unchanged).
//   Full with no pop: word dropped, overflow<=1 (sticky until cleared or reset).
//  Output stage: one holding register (out_port/out_valid) fed by FIFO.
//   Load when FIFO non-empty and (~out_valid | out_ack): out_port<=head, out_valid<=1, pop.
//   Ack with FIFO empty: out_valid<=0 next edge; out_port keeps last value.
//   out_ack while ~out_valid: ignored.
//  Latency: DATA write at edge N enters FIFO; on an idle port out_port/out_valid
//   update at edge N+1. Back-to-back acks sustain one word per clk.
//  Level counts FIFO entries only (excludes holding reg); capacity DEPTH+1 words total.
//  Flush: FIFO empties, out_valid<=0 next edge; out_port holds value. Flush wins over
//   a same-cycle load; an ack in that cycle is consumed normally.
//  Overflow clear and overflow set same cycle: impossible (different addresses).
//  Pointers wrap modulo DEPTH; level width $clog2(DEPTH)+1.
//  Reset mid-transfer: all state cleared asynchronously; pending words lost.
// STRUCTURE
//  Package niosqsys_ctrl_pkg: ADDR_DATA=0, ADDR_STAT=1, STAT_IDLE=0, STAT_FULL=1,
//   STAT_LEVEL_LSB=4, STAT_VALID=9, STAT_OVF=16.
//  Sub-module ctrl_word_fifo: synchronous FIFO (push, pop, flush, head, level, full,
//   empty), DATA_WIDTH x DEPTH. Top holds Avalon decode, holding reg, overflow, read mux.
// TESTING
//  1 Reset, read STAT -> readdata=0x00000001 one clk after address; out_valid=0.
//  2 Write DATA=0xFFFF_FABC, out_ack=0 -> out_port=0xABC, out_valid=1 at edge N+1;
//    read DATA -> 0x00000ABC.
//  3 out_ack=0, write 0x001..0x006 (DEPTH=4) -> 0x001 held, level=4, full=1, 0x006
//    dropped, STAT[16]=1; write STAT 0x10000 -> overflow=0.
//  4 FIFO holds 0x002..0x005, out_ack=1 -> out_port 0x002,0x003,0x004,0x005 on
//    consecutive edges, then out_valid=0, out_port stays 0x005.
//  5 Full FIFO, out_valid=1, write STAT=0x1 -> next edge out_valid=0, level=0, idle=1.
//  6 Full, out_valid=1, out_ack=1, write DATA 0x07E same cycle -> accepted, level=4,
//    no overflow; 0x07E last word out.

Source files
------------

// File: rtl/niosqsys_ctrl_pkg.sv
// Shared register map for the control-word output port and its status word layout.
package niosqsys_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;

    localparam int unsigned STAT_IDLE      = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_LEVEL_LSB = 4;
    localparam int unsigned STAT_LEVEL_W   = 5;
    localparam int unsigned STAT_VALID     = 9;
    localparam int unsigned STAT_OVF       = 16;

    function automatic logic [31:0] pack_stat(
        input logic                    idle,
        input logic                    full,
        input logic [STAT_LEVEL_W-1:0] level,
        input logic                    valid,
        input logic                    ovf
    );
        logic [31:0] s;
        s = '0;
        s[STAT_IDLE]                                = idle;
        s[STAT_FULL]                                = full;
        s[STAT_LEVEL_LSB +: STAT_LEVEL_W]           = level;
        s[STAT_VALID]                               = valid;
        s[STAT_OVF]                                 = ovf;
        return s;
    endfunction

endpackage

// File: rtl/niosqsys_control_words_tx_fifo.sv
// Synchronous FIFO buffering control words between the Avalon write side and the holding register.
module ctrl_word_fifo #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push_i,
    input  logic [DATA_WIDTH-1:0]   push_data_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    output logic [DATA_WIDTH-1:0]   head_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q,  level_d;
    logic                  do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/niosqsys_control_words_tx.sv
// Avalon-MM slave that queues Nios control words and hands them to fabric over valid/ack.
module niosqsys_control_words_tx
    import niosqsys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    input  logic                  out_ack
);

    logic                    wr, wr_data, wr_stat, flush, ovf_clr, load, ovf_set;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic                    fifo_full, fifo_empty;

    logic [DATA_WIDTH-1:0]   out_port_q,  out_port_d;
    logic                    out_valid_q, out_valid_d;
    logic                    ovf_q,       ovf_d;
    logic [31:0]             readdata_q,  readdata_d;
    logic                    unused_wdata;

    assign unused_wdata = ^writedata;

    assign wr      = chipselect & ~write_n;
    assign wr_data = wr & (address == ADDR_DATA);
    assign wr_stat = wr & (address == ADDR_STAT);
    assign flush   = wr_stat & writedata[0];
    assign ovf_clr = wr_stat & writedata[STAT_OVF];

    // Flush suppresses the load so the holding register empties instead of refilling.
    assign load    = ~fifo_empty & (~out_valid_q | out_ack) & ~flush;
    assign ovf_set = wr_data & fifo_full & ~load;

    ctrl_word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (wr_data),
        .push_data_i (writedata[DATA_WIDTH-1:0]),
        .pop_i       (load),
        .flush_i     (flush),
        .head_o      (fifo_head),
        .level_o     (fifo_level),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        out_port_d  = out_port_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_port_d  = fifo_head;
            out_valid_d = 1'b1;
        end else if (out_ack) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d = 32'(out_port_q);
            ADDR_STAT: readdata_d = pack_stat(fifo_empty & ~out_valid_q, fifo_full,
                                              STAT_LEVEL_W'(fifo_level), out_valid_q, ovf_q);
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            readdata_q  <= '0;
        end else begin
            out_port_q  <= out_port_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata  = readdata_q;
    assign out_port  = out_port_q;
    assign out_valid = out_valid_q;

endmodule
